mem2stream: RTL and testbench

MEM2STREAM -- requirements
Module: mem2stream

---
 rtl/mem2stream.sv | 87 ++++++++
 tb/tb_mem2stream.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem2stream.sv
// Drains fixed-size frames from a slot RAM into a byte stream with valid/ready handshake.
// Per byte: FETCH (read strobe), LATCH (capture RAM data), SEND (hold until accepted).
module mem2stream #(
  parameter int SLOT_BITS   = 5,
  parameter int FRAME_BYTES = 6
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [SLOT_BITS-1:0] write_slot,
  output logic [SLOT_BITS+2:0] ram_addr,
  output logic                 ram_read_en,
  input  logic [7:0]           ram_data,
  output logic [7:0]           data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic [SLOT_BITS-1:0] read_slot,
  output logic                 empty
);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, SEND} state_t;

  localparam logic [2:0] LAST_OFF = 3'(FRAME_BYTES - 1);

  state_t               state_q;
  logic [2:0]           offset_q;
  logic [SLOT_BITS-1:0] read_slot_q;
  logic [7:0]           data_out_q;
  logic                 data_valid_q;
  logic                 ram_read_en_q;

  assign empty       = (read_slot_q == write_slot);
  assign ram_addr    = {read_slot_q, offset_q};
  assign ram_read_en = ram_read_en_q;
  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign read_slot   = read_slot_q;

  // Emptiness is only consulted in IDLE, so a moving write_slot cannot disturb a frame in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      offset_q      <= 3'd0;
      read_slot_q   <= '0;
      data_out_q    <= 8'd0;
      data_valid_q  <= 1'b0;
      ram_read_en_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            state_q       <= FETCH;
            ram_read_en_q <= 1'b1;
          end
        end
        FETCH: begin
          state_q       <= LATCH;
          ram_read_en_q <= 1'b0;
        end
        LATCH: begin
          data_out_q   <= ram_data;
          data_valid_q <= 1'b1;
          state_q      <= SEND;
        end
        SEND: begin
          if (data_ready) begin
            data_valid_q <= 1'b0;
            if (offset_q == LAST_OFF) begin
              offset_q    <= 3'd0;
              read_slot_q <= read_slot_q + SLOT_BITS'(1);
              state_q     <= IDLE;
            end else begin
              offset_q      <= offset_q + 3'd1;
              ram_read_en_q <= 1'b1;
              state_q       <= FETCH;
            end
          end
        end
        default: begin
          state_q       <= IDLE;
          ram_read_en_q <= 1'b0;
          data_valid_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem2stream.sv
// Bench for mem2stream: slot RAM model, stream scoreboard, per-scenario tasks.
module tb_mem2stream;
  localparam int SB = 5;
  localparam int FB = 6;
  localparam int NSLOT = 1 << SB;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic [SB-1:0] write_slot = '0;
  logic [SB+2:0] ram_addr;
  logic          ram_read_en;
  logic [7:0]    ram_data = 8'd0;
  logic [7:0]    data_out;
  logic          data_valid;
  logic          data_ready = 1'b0;
  logic [SB-1:0] read_slot;
  logic          empty;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mem [0:255];
  logic [7:0] got[$];
  int         stamp[$];
  logic [7:0] exp_q[$];
  logic [7:0] addr_log[$];

  mem2stream #(.SLOT_BITS(SB), .FRAME_BYTES(FB)) dut (
    .clock(clock), .reset_n(reset_n), .write_slot(write_slot),
    .ram_addr(ram_addr), .ram_read_en(ram_read_en), .ram_data(ram_data),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .read_slot(read_slot), .empty(empty)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous-read RAM: data appears the clock after a strobed address.
  always @(posedge clock) if (ram_read_en) ram_data <= mem[ram_addr];

  // Scoreboard capture plus address-map check on every RAM read.
  always @(negedge clock) begin
    if (reset_n) begin
      if (data_valid && data_ready) begin
        got.push_back(data_out);
        stamp.push_back(cyc);
      end
      if (ram_read_en) begin
        addr_log.push_back(ram_addr);
        vectors++;
        if (ram_addr[2:0] >= FB || ram_addr[SB+2:3] !== read_slot) begin
          errors++;
          $display("FAIL ram_addr_map actual=%h read_slot=%0d required offset<%0d and slot match",
                   ram_addr, read_slot, FB);
        end
      end
    end
  end

  task automatic do_reset(input logic [SB-1:0] ws);
    @(posedge clock); #1;
    reset_n = 1'b0; write_slot = ws; data_ready = 1'b0;
    @(posedge clock); #1;
    got.delete(); stamp.delete(); addr_log.delete(); exp_q.delete();
    reset_n = 1'b1;
  endtask

  task automatic run_until(input int n, input int budget, input bit rnd);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(posedge clock); #1;
      if (rnd) data_ready = ($urandom_range(0, 3) != 0);
      k++;
    end
  endtask

  // Reference: a frame is simply the first FB bytes of each slot, slots in ring order.
  task automatic build_exp(input int first, input int n);
    for (int s = 0; s < n; s++)
      for (int o = 0; o < FB; o++)
        exp_q.push_back(mem[((first + s) % NSLOT) * 8 + o]);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    #1 reset_n = 1'b0; write_slot = '0; data_ready = 1'b0;
    #2;
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty actual=%b required=1", empty); end
    vectors++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid actual=%b required=0", data_valid); end
    vectors++; if (ram_read_en !== 1'b0) begin errors++; $display("FAIL rst_rden actual=%b required=0", ram_read_en); end
    vectors++; if (read_slot !== '0) begin errors++; $display("FAIL rst_read_slot actual=%0d required=0", read_slot); end
    vectors++; if (data_out !== 8'd0) begin errors++; $display("FAIL rst_data_out actual=%h required=00", data_out); end
    vectors++; if (ram_addr !== '0) begin errors++; $display("FAIL rst_ram_addr actual=%h required=00", ram_addr); end
    @(posedge clock); #1;
    reset_n = 1'b1; data_ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    vectors++; if (addr_log.size() != 0) begin errors++; $display("FAIL idle_no_reads actual=%0d required=0", addr_log.size()); end
    vectors++; if (data_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL idle_state valid=%b empty=%b required 0/1", data_valid, empty); end
  endtask

  task automatic test_single_frame;
    logic [7:0] frame [0:5];
    frame = '{8'h0D, 8'hFF, 8'hFF, 8'h00, 8'h80, 8'h5A};
    do_reset('0);
    for (int o = 0; o < FB; o++) mem[o] = frame[o];
    data_ready = 1'b1;
    write_slot = 5'd1;
    build_exp(0, 1);
    @(posedge clock); #1;
    vectors++; if (ram_read_en !== 1'b1 || ram_addr !== 8'h00) begin errors++; $display("FAIL lat_fetch rden=%b addr=%h required 1/00", ram_read_en, ram_addr); end
    @(posedge clock); #1;
    vectors++; if (ram_read_en !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL lat_latch rden=%b valid=%b required 0/0", ram_read_en, data_valid); end
    @(posedge clock); #1;
    vectors++; if (data_valid !== 1'b1 || data_out !== 8'h0D) begin errors++; $display("FAIL lat_send valid=%b data=%h required 1/0D", data_valid, data_out); end
    run_until(6, 100, 1'b0);
    vectors++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL single_count actual=%0d required=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte[%0d] actual=%h required=%h", i, got[i], exp_q[i]); end
    end
    for (int i = 1; i < stamp.size(); i++) begin
      vectors++;
      if (stamp[i] - stamp[i-1] != 3) begin errors++; $display("FAIL byte_period[%0d] actual=%0d required=3", i, stamp[i] - stamp[i-1]); end
    end
    @(posedge clock); #1;
    vectors++; if (read_slot !== 5'd1 || empty !== 1'b1 || data_valid !== 1'b0) begin
      errors++; $display("FAIL single_end read_slot=%0d empty=%b valid=%b required 1/1/0", read_slot, empty, data_valid);
    end
  endtask

  task automatic test_stall;
    int k = 0;
    do_reset('0);
    data_ready = 1'b1;
    write_slot = 5'd1;
    build_exp(0, 1);
    while (!(data_valid && got.size() == 2) && k < 50) begin @(posedge clock); #1; k++; end
    vectors++; if (!(data_valid && got.size() == 2)) begin errors++; $display("FAIL stall_reach actual=%0d bytes required=2 with valid", got.size()); end
    data_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      vectors++;
      if (data_out !== 8'hFF || data_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] data=%h valid=%b required FF/1", c, data_out, data_valid); end
    end
    data_ready = 1'b1;
    run_until(6, 100, 1'b0);
    vectors++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL stall_count actual=%0d required=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte[%0d] actual=%h required=%h", i, got[i], exp_q[i]); end
    end
    vectors++; if (stamp.size() > 2 && stamp[2] - stamp[1] != 13) begin errors++; $display("FAIL stall_gap actual=%0d required=13", stamp[2] - stamp[1]); end
  endtask

  task automatic test_wrap;
    do_reset(5'd31);
    run_until(31 * FB, 4000, 1'b1);
    data_ready = 1'b1;
    build_exp(0, 31);
    vectors++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count actual=%0d required=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_byte[%0d] actual=%h required=%h", i, got[i], exp_q[i]); end
    end
    vectors++; if (read_slot !== 5'd31 || empty !== 1'b1) begin errors++; $display("FAIL pre_wrap read_slot=%0d empty=%b required 31/1", read_slot, empty); end
    got.delete(); stamp.delete(); addr_log.delete(); exp_q.delete();
    write_slot = 5'd0;
    build_exp(31, 1);
    run_until(FB, 200, 1'b1);
    data_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_byte[%0d] required=%h", i, exp_q[i]); end
    end
    vectors++; if (addr_log.size() != FB) begin errors++; $display("FAIL wrap_reads actual=%0d required=%0d", addr_log.size(), FB); end
    for (int i = 0; i < addr_log.size(); i++) begin
      vectors++;
      if (addr_log[i] !== 8'(8'hF8 + i)) begin errors++; $display("FAIL wrap_addr[%0d] actual=%h required=%h", i, addr_log[i], 8'(8'hF8 + i)); end
    end
    vectors++; if (read_slot !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL post_wrap read_slot=%0d empty=%b required 0/1", read_slot, empty); end
  endtask

  task automatic test_reset_mid;
    int k = 0;
    do_reset(5'd4);
    run_until(4 * FB, 2000, 1'b1);
    write_slot = 5'd5;
    data_ready = 1'b1;
    build_exp(0, 5);
    while (!(data_valid && got.size() == 27) && k < 200) begin @(posedge clock); #1; data_ready = 1'b1; k++; end
    vectors++; if (!(data_valid && got.size() == 27)) begin errors++; $display("FAIL mid_reach actual=%0d bytes required=27 with valid", got.size()); end
    for (int i = 0; i < 27 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL mid_byte[%0d] actual=%h required=%h", i, got[i], exp_q[i]); end
    end
    reset_n = 1'b0;
    #1;
    vectors++; if (data_valid !== 1'b0 || ram_read_en !== 1'b0) begin errors++; $display("FAIL async_rst valid=%b rden=%b required 0/0", data_valid, ram_read_en); end
    vectors++; if (read_slot !== '0 || ram_addr !== '0) begin errors++; $display("FAIL async_rst_ptr slot=%0d addr=%h required 0/00", read_slot, ram_addr); end
    @(posedge clock); #1;
    got.delete(); stamp.delete(); addr_log.delete(); exp_q.delete();
    reset_n = 1'b1;
    #2;
    vectors++; if (data_valid !== 1'b0 || ram_read_en !== 1'b0 || ram_addr !== '0) begin
      errors++; $display("FAIL post_release valid=%b rden=%b addr=%h required 0/0/00", data_valid, ram_read_en, ram_addr);
    end
    build_exp(0, 5);
    run_until(5 * FB, 2000, 1'b1);
    data_ready = 1'b1;
    vectors++; if (addr_log.size() == 0 || addr_log[0] !== 8'h00) begin errors++; $display("FAIL restart_addr required first read at 00"); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin errors++; $display("FAIL restart_byte[%0d] required=%h", i, exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int k = 0;
    do_reset(5'd2);
    data_ready = 1'b1;
    while (!(data_valid && got.size() == FB) && k < 100) begin @(posedge clock); #1; k++; end
    vectors++; if (!(data_valid && got.size() == FB)) begin errors++; $display("FAIL b2b_reach actual=%0d bytes required=%0d with valid", got.size(), FB); end
    write_slot = 5'd3;
    run_until(3 * FB, 300, 1'b0);
    build_exp(0, 3);
    vectors++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count actual=%0d required=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte[%0d] actual=%h required=%h", i, got[i], exp_q[i]); end
    end
    if (stamp.size() >= 13) begin
      vectors++;
      if (stamp[11] - stamp[10] != 3) begin errors++; $display("FAIL b2b_inframe actual=%0d required=3", stamp[11] - stamp[10]); end
      vectors++;
      if (stamp[12] - stamp[11] != 4) begin errors++; $display("FAIL b2b_gap actual=%0d required=4", stamp[12] - stamp[11]); end
    end
    vectors++; if (read_slot !== 5'd3 || empty !== 1'b1) begin errors++; $display("FAIL b2b_end read_slot=%0d empty=%b required 3/1", read_slot, empty); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
